uart_hex_frame_parser: RTL and testbench
========================================

Name: uart_hex_frame_parser

Overview:
Parametrised ASCII-hex frame parser between the UART receiver and the fixed-point datapath. It collects NUM_CH × DIGITS hex characters and packs them MSB-nibble first into NUM_CH words. All words are published together with a one-cycle valid pulse. It adds invalid-character rejection, an inter-character timeout, atomic output update and error reporting.

Parameters:
NUM_CH, 3, number of output words per frame (1..8)
DIGITS, 8, hex digits per word; word width W = 4*DIGITS (1..16)
TIMEOUT_CYC, 0, max clk cycles between characters inside a frame; 0 = timeout disabled

Ports:
clk  in  1  UART-domain clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received ASCII character
rx_strobe  in  1  character-ready level; a character is taken on its rising edge
dataerror  in  1  receiver parity/data error
frameerror  in  1  receiver stop-bit error
clr  in  1  synchronous clear
data_out  out  NUM_CH*W  packed words; channel 0 in [W-1:0]
valid  out  1  one-cycle pulse when data_out updates
busy  out  1  frame in progress (1 or more digits held)
frame_err  out  1  one-cycle pulse when a frame is aborted
err_code  out  2  abort cause: 0 none, 1 bad char, 2 rx error, 3 timeout; held until next abort or valid

Behaviour:
- Reset (async, rst_n=0): data_out=0, valid=0, busy=0, frame_err=0, err_code=0. FSM goes to IDLE, counters 0, strobe history register 0.
- Edge detect: take = rx_strobe & ~strobe_q. strobe_q is a registered copy of rx_strobe. A character is consumed on the clk edge where take=1, so there is no extra latency.
- Decode: '0'-'9' → 0-9, 'A'-'F' and 'a'-'f' → 10-15. Any other code is a bad char; it never decodes as 0.
- FSM states:
  - IDLE: first good digit → COLLECT.
  - COLLECT: digit_cnt counts 0..DIGITS-1 and ch_cnt counts 0..NUM_CH-1. Each digit shifts into a shadow register: shadow[ch] <= {shadow[ch][W-5:0], nib}.
  - On the final digit (ch_cnt=NUM_CH-1, digit_cnt=DIGITS-1): all shadows are copied to data_out on that edge, valid=1 the following cycle only, then return to IDLE.
- data_out changes only on frame completion. Partial frames are never visible.
- Abort, from COLLECT or IDLE:
  - bad char → err 1.
  - dataerror|frameerror high on any cycle → err 2.
  - timeout → err 3.
  - On abort: counters cleared, shadows cleared, frame_err pulses once, data_out retained, → IDLE.
  - A bad char in IDLE also pulses frame_err.
- Timeout: gap counter runs only while busy and reloads on every take. When TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC with no take → abort.
- Simultaneous events, in priority order: clr > rx error > take. A bad char arriving with an rx error reports err 2.
- clr: same as reset except strobe_q keeps tracking. data_out and err_code go to 0, and frame_err does not pulse.
- Back-to-back: a take in the cycle after completion starts a new frame. valid and the first digit do not conflict.
- busy = (state==COLLECT).

Optional Feature:
UART_HEX_SYNC_EN.
- Defined: IDLE ignores all characters except sync '#' (0x23). '#' moves to COLLECT with counters 0 and does not contribute a digit. A '#' inside COLLECT restarts the frame: shadows and counters cleared, no frame_err. Non-sync characters in IDLE do not raise frame_err.
- Undefined: no sync character; the first good digit starts the frame, and '#' is a bad char.

Decomposition:
- Package uart_pkg holds:
  - ASCII constants ('0', '9', 'A', 'F', 'a', 'f', '#').
  - err_code enumeration localparams (ERR_NONE, ERR_CHAR, ERR_RX, ERR_TMO).
  - FSM state encodings.
- One combinational sub-module, uart_hex_decode: rx_data → nib[3:0], is_hex, is_sync.

Test Plan:
- Defaults; send "0000000A" "FFFFFFFF" "12345678" with gaps of 20 cycles → single valid pulse after 24th char; data_out = {32'h12345678, 32'hFFFFFFFF, 32'h0000000A}; busy low afterwards.
- Lowercase plus NUM_CH=1, DIGITS=4; send "beEF" → data_out=16'hBEEF, valid 1 cycle.
- Prior data_out=X; send "12G" → frame_err pulse on 'G', err_code=1, data_out unchanged. A following full frame completes normally.
- Assert frameerror for 1 cycle after 5 digits → frame_err, err_code=2, busy=0. Assert clr → data_out=0, err_code=0.
- TIMEOUT_CYC=100; 3 digits then 101 idle cycles → frame_err, err_code=3. With gaps of 99 cycles no abort occurs.
- UART_HEX_SYNC_EN defined: "x5#" + 24 digits → valid and correct data. "#12#" + 24 digits → first partial frame discarded, no frame_err, second frame valid.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared constants for the UART ASCII-hex frame parser
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_UA   = 8'h41;
  localparam logic [7:0] ASCII_UF   = 8'h46;
  localparam logic [7:0] ASCII_LA   = 8'h61;
  localparam logic [7:0] ASCII_LF   = 8'h66;
  localparam logic [7:0] ASCII_SYNC = 8'h23;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHAR = 2'd1;
  localparam logic [1:0] ERR_RX   = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_hex_decode.sv
`default_nettype none
// ============================================================================
// uart_hex_decode : ASCII character to hex nibble, with hex/sync flags
// Rev 1.0
// ============================================================================
module uart_hex_decode
  import uart_pkg::*;
(
  input  logic [7:0] rx_data,
  output logic [3:0] nib,
  output logic       is_hex,
  output logic       is_sync
);

  // Digits keep their low nibble; letters in either case sit at low nibble 1..6.
  always_comb begin
    nib    = 4'h0;
    is_hex = 1'b0;
    if (rx_data >= ASCII_0 && rx_data <= ASCII_9) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0];
    end else if ((rx_data >= ASCII_UA && rx_data <= ASCII_UF) ||
                 (rx_data >= ASCII_LA && rx_data <= ASCII_LF)) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0] + 4'd9;
    end
  end

  assign is_sync = (rx_data == ASCII_SYNC);

endmodule
`default_nettype wire

// File: rtl/uart_hex_frame_parser.sv
`default_nettype none
// ============================================================================
// uart_hex_frame_parser : packs NUM_CH x DIGITS ASCII-hex characters into words
// Optional build macro UART_HEX_SYNC_EN: frames start with '#'.   Rev 1.0
// ============================================================================
module uart_hex_frame_parser
  import uart_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int DIGITS      = 8,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_strobe,
  input  logic                       dataerror,
  input  logic                       frameerror,
  input  logic                       clr,
  output logic [NUM_CH*4*DIGITS-1:0] data_out,
  output logic                       valid,
  output logic                       busy,
  output logic                       frame_err,
  output logic [1:0]                 err_code
);

  localparam int W     = 4 * DIGITS;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [DG_W-1:0]  DG_LAST  = DG_W'(DIGITS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
  logic [DG_W-1:0]     digit_cnt_q, digit_cnt_d;
  logic [TMO_W-1:0]    gap_q, gap_d;
  logic [NUM_CH*W-1:0] shadow_q, shadow_d;
  logic [NUM_CH*W-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic [1:0]          err_q, err_d;
  logic                strobe_q;

  logic [3:0]          nib;
  logic                is_hex, is_sync;
  logic                take, rx_err, tmo_hit;
  logic                abort;
  logic [1:0]          abort_code;
  logic [W+3:0]        shifted;

  uart_hex_decode u_decode (
    .rx_data (rx_data),
    .nib     (nib),
    .is_hex  (is_hex),
    .is_sync (is_sync)
  );

`ifndef UART_HEX_SYNC_EN
  logic unused_sync;
  assign unused_sync = is_sync;
`endif

  assign take    = rx_strobe & ~strobe_q;
  assign rx_err  = dataerror | frameerror;
  assign busy    = (state_q == ST_COLLECT);
  assign tmo_hit = (TIMEOUT_CYC > 0) && busy && (gap_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    ch_cnt_d    = ch_cnt_q;
    digit_cnt_d = digit_cnt_q;
    gap_d       = gap_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    err_d       = err_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    abort       = 1'b0;
    abort_code  = ERR_NONE;
    shifted     = '0;

    if (clr) begin
      state_d     = ST_IDLE;
      ch_cnt_d    = '0;
      digit_cnt_d = '0;
      gap_d       = '0;
      shadow_d    = '0;
      data_d      = '0;
      err_d       = ERR_NONE;
    end else if (rx_err) begin
      abort      = 1'b1;
      abort_code = ERR_RX;
    end else if (take) begin
      gap_d = '0;
`ifdef UART_HEX_SYNC_EN
      if (is_sync) begin
        state_d     = ST_COLLECT;
        ch_cnt_d    = '0;
        digit_cnt_d = '0;
        shadow_d    = '0;
      end else if (busy && !is_hex) begin
        abort      = 1'b1;
        abort_code = ERR_CHAR;
      end else if (busy) begin
`else
      if (!is_hex) begin
        abort      = 1'b1;
        abort_code = ERR_CHAR;
      end else begin
`endif
        state_d = ST_COLLECT;
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_cnt_q == CH_W'(c)) begin
            shifted              = {shadow_q[c*W +: W], nib};
            shadow_d[c*W +: W]   = shifted[W-1:0];
          end
        end
        if (digit_cnt_q == DG_LAST) begin
          digit_cnt_d = '0;
          if (ch_cnt_q == CH_LAST) begin
            // Publish the whole frame at once, including the digit just shifted in.
            data_d   = shadow_d;
            valid_d  = 1'b1;
            err_d    = ERR_NONE;
            state_d  = ST_IDLE;
            ch_cnt_d = '0;
            shadow_d = '0;
          end else begin
            ch_cnt_d = ch_cnt_q + 1'b1;
          end
        end else begin
          digit_cnt_d = digit_cnt_q + 1'b1;
        end
      end
    end else if (tmo_hit) begin
      abort      = 1'b1;
      abort_code = ERR_TMO;
    end else if (busy) begin
      gap_d = gap_q + 1'b1;
    end

    if (abort) begin
      state_d     = ST_IDLE;
      ch_cnt_d    = '0;
      digit_cnt_d = '0;
      gap_d       = '0;
      shadow_d    = '0;
      ferr_d      = 1'b1;
      err_d       = abort_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ch_cnt_q    <= '0;
      digit_cnt_q <= '0;
      gap_q       <= '0;
      shadow_q    <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      err_q       <= ERR_NONE;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_cnt_q    <= ch_cnt_d;
      digit_cnt_q <= digit_cnt_d;
      gap_q       <= gap_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      err_q       <= err_d;
      strobe_q    <= rx_strobe;
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign err_code  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_frame_parser.sv
`default_nettype none
// ============================================================================
// tb_uart_hex_frame_parser : three parser configurations driven by directed and
// random character streams, checked against a digit-list reference model. Rev 1.0
// ============================================================================
module tb_uart_hex_frame_parser;

`ifdef UART_HEX_SYNC_EN
  localparam string PFX = "#";
`else
  localparam string PFX = "";
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic [2:0]  strobe, derr, ferr_in, clr_v;

  logic [95:0] d0_data;
  logic [15:0] d1_data, d2_data;
  logic [2:0]  o_valid, o_busy, o_ferr;
  logic [1:0]  o_err0, o_err1, o_err2;

  int          n_tests = 0;
  int          n_fail  = 0;

  // reference model: per-instance list of received digits
  int          nch [3];
  int          dig [3];
  int          nd  [3];
  bit          inf [3];
  logic [3:0]  bufv [3][24];
  logic [95:0] exp_data [3];
  logic [1:0]  exp_err  [3];

  always #5 clk = ~clk;

  uart_hex_frame_parser #(.NUM_CH(3), .DIGITS(8), .TIMEOUT_CYC(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_strobe(strobe[0]),
    .dataerror(derr[0]), .frameerror(ferr_in[0]), .clr(clr_v[0]),
    .data_out(d0_data), .valid(o_valid[0]), .busy(o_busy[0]),
    .frame_err(o_ferr[0]), .err_code(o_err0));

  uart_hex_frame_parser #(.NUM_CH(1), .DIGITS(4), .TIMEOUT_CYC(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_strobe(strobe[1]),
    .dataerror(derr[1]), .frameerror(ferr_in[1]), .clr(clr_v[1]),
    .data_out(d1_data), .valid(o_valid[1]), .busy(o_busy[1]),
    .frame_err(o_ferr[1]), .err_code(o_err1));

  uart_hex_frame_parser #(.NUM_CH(2), .DIGITS(2), .TIMEOUT_CYC(100)) u_d2 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_strobe(strobe[2]),
    .dataerror(derr[2]), .frameerror(ferr_in[2]), .clr(clr_v[2]),
    .data_out(d2_data), .valid(o_valid[2]), .busy(o_busy[2]),
    .frame_err(o_ferr[2]), .err_code(o_err2));

  function automatic bit hexval(input logic [7:0] c, output logic [3:0] v);
    string      hexd = "0123456789abcdef";
    logic [7:0] lc;
    lc = (c >= "A" && c <= "Z") ? c + 8'd32 : c;
    v  = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (hexd[i] == lc) begin
        v = i[3:0];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic m_reset(input int s);
    nd[s] = 0; inf[s] = 1'b0; exp_data[s] = '0; exp_err[s] = 2'd0;
  endtask

  task automatic m_abort(input int s, input logic [1:0] code);
    nd[s] = 0; inf[s] = 1'b0; exp_err[s] = code;
  endtask

  task automatic m_char(input int s, input logic [7:0] c, output bit ev, output bit ef);
    logic [3:0] v;
    bit         ok;
    ev = 1'b0; ef = 1'b0;
    ok = hexval(c, v);
`ifdef UART_HEX_SYNC_EN
    if (c == "#") begin inf[s] = 1'b1; nd[s] = 0; return; end
    if (!inf[s]) return;
`endif
    if (!ok) begin m_abort(s, 2'd1); ef = 1'b1; return; end
    bufv[s][nd[s]] = v;
    nd[s]++;
    inf[s] = 1'b1;
    if (nd[s] == nch[s] * dig[s]) begin
      // digit i belongs to word i/dig, most significant digit first
      exp_data[s] = '0;
      for (int i = 0; i < nd[s]; i++)
        exp_data[s] |= 96'(bufv[s][i]) << (4 * (dig[s] * (i / dig[s]) + dig[s] - 1 - i % dig[s]));
      nd[s] = 0; inf[s] = 1'b0; exp_err[s] = 2'd0; ev = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int s, input string tag, input bit ev, input bit ef);
    logic [95:0] dat;
    logic [1:0]  e;
    case (s)
      0:       begin dat = d0_data;         e = o_err0; end
      1:       begin dat = {80'd0, d1_data}; e = o_err1; end
      default: begin dat = {80'd0, d2_data}; e = o_err2; end
    endcase
    check($sformatf("%s.d%0d.valid", tag, s), 96'(o_valid[s]), 96'(ev));
    check($sformatf("%s.d%0d.frame_err", tag, s), 96'(o_ferr[s]), 96'(ef));
    check($sformatf("%s.d%0d.busy", tag, s), 96'(o_busy[s]), 96'(inf[s]));
    check($sformatf("%s.d%0d.err_code", tag, s), 96'(e), 96'(exp_err[s]));
    check($sformatf("%s.d%0d.data_out", tag, s), dat, exp_data[s]);
  endtask

  // one character: strobe high for one cycle, then 'gap' idle clock edges
  task automatic send(input int s, input logic [7:0] c, input bit rxe, input int gap, input string tag);
    bit ev, ef;
    rx_data = c; strobe[s] = 1'b1; derr[s] = rxe;
    @(posedge clk); #1;
    strobe[s] = 1'b0; derr[s] = 1'b0;
    if (rxe) begin m_abort(s, 2'd2); ev = 1'b0; ef = 1'b1; end
    else m_char(s, c, ev, ef);
    check_dut(s, tag, ev, ef);
    @(posedge clk); #1;
    check_dut(s, {tag, "+1"}, 1'b0, 1'b0);
    repeat (gap - 1) @(posedge clk);
    #1;
  endtask

  task automatic send_str(input int s, input string str, input int gap, input string tag);
    for (int i = 0; i < str.len(); i++) send(s, str[i], 1'b0, gap, tag);
  endtask

  task automatic pulse_rx(input int s, input string tag);
    ferr_in[s] = 1'b1;
    @(posedge clk); #1;
    ferr_in[s] = 1'b0;
    m_abort(s, 2'd2);
    check_dut(s, tag, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_dut(s, {tag, "+1"}, 1'b0, 1'b0);
  endtask

  task automatic pulse_clr(input int s, input string tag);
    clr_v[s] = 1'b1;
    @(posedge clk); #1;
    clr_v[s] = 1'b0;
    m_reset(s);
    check_dut(s, tag, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string hexs = "0123456789ABCDEFabcdef";
    string bads = "/:@`GgZz x";
    int    r, s, gap;

    nch = '{3, 1, 2};
    dig = '{8, 4, 2};
    for (int i = 0; i < 3; i++) m_reset(i);
    rst_n = 1'b0; rx_data = 8'h00; strobe = '0; derr = '0; ferr_in = '0; clr_v = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) check_dut(i, "reset", 1'b0, 1'b0);

    send_str(0, {PFX, "0000000AFFFFFFFF12345678"}, 20, "frame3x8");
    check("frame3x8.lit", d0_data, 96'h12345678_FFFFFFFF_0000000A);

    send_str(1, {PFX, "beEF"}, 2, "lower");
    check("lower.lit", {80'd0, d1_data}, 96'hBEEF);

    send_str(1, {PFX, "12G"}, 1, "badG");
    check("badG.err.lit", 96'(o_err1), 96'd1);
    check("badG.data.lit", {80'd0, d1_data}, 96'hBEEF);
    send_str(1, {PFX, "C0DE"}, 1, "after_bad");
    check("after_bad.lit", {80'd0, d1_data}, 96'hC0DE);

    send_str(1, "/:@`g#", 1, "edges");
    pulse_clr(1, "edges_clr");

    send_str(0, {PFX, "12345"}, 1, "rxerr_pre");
    pulse_rx(0, "rxerr");
    check("rxerr.err.lit", 96'(o_err0), 96'd2);
    pulse_clr(0, "clr");
    check("clr.data.lit", d0_data, 96'd0);

    send_str(1, {PFX, "9"}, 1, "simul_pre");
    send(1, "Z", 1'b1, 1, "simul");
    check("simul.err.lit", 96'(o_err1), 96'd2);

    send_str(1, {PFX, "ab"}, 1, "clr_mid");
    pulse_clr(1, "clr_mid_clr");
    send_str(1, {PFX, "1234"}, 1, "clr_mid_post");
    check("clr_mid.lit", {80'd0, d1_data}, 96'h1234);

    send_str(2, {PFX, "12"}, 1, "tmo_pre");
    send(2, "3", 1'b0, 99, "tmo_last");
    check_dut(2, "tmo_99idle", 1'b0, 1'b0);
    @(posedge clk); #1;
    m_abort(2, 2'd3);
    check_dut(2, "tmo_hit", 1'b0, 1'b1);
    check("tmo.err.lit", 96'(o_err2), 96'd3);
    send_str(2, {PFX, "ABCD"}, 99, "tmo99");
    check("tmo99.lit", {80'd0, d2_data}, 96'hCDAB);

    send_str(0, {PFX, "1"}, 300, "notmo_first");
    send_str(0, "23456789abcdef012345678", 1, "notmo_rest");
    check("notmo.lit", d0_data, 96'h12345678_9ABCDEF0_12345678);

`ifdef UART_HEX_SYNC_EN
    send_str(0, "x5#", 2, "sync_a_pre");
    send_str(0, "000000010000000200000003", 1, "sync_a");
    check("sync_a.lit", d0_data, 96'h00000003_00000002_00000001);
    send_str(0, "#12#", 1, "sync_b_pre");
    send_str(0, "ABCDEF0123456789DEADBEEF", 1, "sync_b");
    check("sync_b.lit", d0_data, 96'hDEADBEEF_23456789_ABCDEF01);
`else
    send(1, "#", 1'b0, 1, "hash_bad");
    check("hash_bad.err.lit", 96'(o_err1), 96'd1);
`endif

    for (int k = 0; k < 600; k++) begin
      s   = k % 3;
      r   = int'($urandom_range(0, 99));
      gap = int'($urandom_range(1, 3));
      if (r < 78)      send(s, hexs[$urandom_range(0, 21)], 1'b0, gap, "rnd_hex");
      else if (r < 86) send(s, bads[$urandom_range(0, 9)], 1'b0, gap, "rnd_bad");
      else if (r < 92) send(s, "#", 1'b0, gap, "rnd_sync");
      else if (r < 96) send(s, hexs[$urandom_range(0, 21)], 1'b1, gap, "rnd_rxe");
      else if (r < 98) pulse_rx(s, "rnd_rx");
      else             pulse_clr(s, "rnd_clr");
    end

    send_str(0, {PFX, "abc"}, 1, "arst_pre");
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) m_reset(i);
    for (int i = 0; i < 3; i++) check_dut(i, "async_rst", 1'b0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) check_dut(i, "after_rst", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
